// File: rtl/fb_pixel_writer_if.sv
// rtl/fb_pixel_writer_if.sv - renderer pixel stream and framebuffer write port bundle
interface fb_pixel_writer_if #(
  parameter int CORDW = 16,
  parameter int CIDXW = 4,
  parameter int ADDRW = 16
);
  logic signed [CORDW-1:0] x;
  logic signed [CORDW-1:0] y;
  logic [CIDXW-1:0]        cidx;
  logic                    drawing;
  logic                    oe;
  logic                    mem_we;
  logic                    mem_ready;
  logic [ADDRW-1:0]        mem_addr;
  logic [CIDXW-1:0]        mem_data;

  modport master (
    output x, y, cidx, drawing, mem_ready,
    input  oe, mem_we, mem_addr, mem_data
  );

  modport slave (
    input  x, y, cidx, drawing, mem_ready,
    output oe, mem_we, mem_addr, mem_data
  );
endinterface

// File: rtl/fb_pixel_writer.sv
// rtl/fb_pixel_writer.sv - clip, address and buffer renderer pixels into framebuffer writes
// Optional FB_TRANSPARENT_EN: drop in-bounds pixels with colour index 0.
module fb_pixel_writer #(
  parameter int CORDW      = 16,
  parameter int CIDXW      = 4,
  parameter int FB_WIDTH   = 320,
  parameter int FB_HEIGHT  = 180,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDRW      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  fb_pixel_writer_if.slave    bus,
  output logic [15:0]         clip_cnt,
  output logic                idle
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic signed [CORDW-1:0] W_S = CORDW'(FB_WIDTH);
  localparam logic signed [CORDW-1:0] H_S = CORDW'(FB_HEIGHT);

  logic                    p1_valid_q, p1_valid_d;
  logic signed [CORDW-1:0] p1_x_q, p1_x_d;
  logic signed [CORDW-1:0] p1_y_q, p1_y_d;
  logic [CIDXW-1:0]        p1_cidx_q, p1_cidx_d;
  logic                    p2_valid_q, p2_valid_d;
  logic [ADDRW-1:0]        p2_addr_q, p2_addr_d;
  logic [CIDXW-1:0]        p2_cidx_q, p2_cidx_d;
  logic [ADDRW-1:0]        fifo_addr_q [FIFO_DEPTH];
  logic [ADDRW-1:0]        fifo_addr_d [FIFO_DEPTH];
  logic [CIDXW-1:0]        fifo_data_q [FIFO_DEPTH];
  logic [CIDXW-1:0]        fifo_data_d [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW:0]             cnt_q, cnt_d;
  logic [15:0]             clip_cnt_q, clip_cnt_d;
  logic [ADDRW-1:0]        last_addr_q, last_addr_d;
  logic [CIDXW-1:0]        last_data_q, last_data_d;

  logic [PW+1:0] occ;
  logic          oe_w;
  logic          accept;
  logic          out_of_bounds;
  logic          transparent;
  logic          fifo_nempty;
  logic          push;
  logic          pop;

  always_comb begin
    // Pixels already in the pipeline reserve a FIFO slot, so oe never lets the FIFO overflow
    occ = (PW+2)'(cnt_q) + (PW+2)'(p1_valid_q) + (PW+2)'(p2_valid_q);
    oe_w = occ < (PW+2)'(FIFO_DEPTH);
    accept = bus.drawing && oe_w;

    out_of_bounds = p1_x_q[CORDW-1] || (p1_x_q >= W_S) ||
                    p1_y_q[CORDW-1] || (p1_y_q >= H_S);
`ifdef FB_TRANSPARENT_EN
    transparent = (p1_cidx_q == '0);
`else
    transparent = 1'b0;
`endif

    fifo_nempty = (cnt_q != '0);
    push = p2_valid_q;
    pop  = fifo_nempty && bus.mem_ready;

    p1_valid_d = accept;
    p1_x_d     = accept ? bus.x    : p1_x_q;
    p1_y_d     = accept ? bus.y    : p1_y_q;
    p1_cidx_d  = accept ? bus.cidx : p1_cidx_q;

    p2_valid_d = p1_valid_q && !out_of_bounds && !transparent;
    p2_addr_d  = p2_addr_q;
    p2_cidx_d  = p2_cidx_q;
    if (p2_valid_d) begin
      p2_addr_d = ADDRW'(32'(p1_y_q) * FB_WIDTH + 32'(p1_x_q));
      p2_cidx_d = p1_cidx_q;
    end

    clip_cnt_d = clip_cnt_q;
    if (p1_valid_q && out_of_bounds && (clip_cnt_q != 16'hFFFF))
      clip_cnt_d = clip_cnt_q + 16'd1;

    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
    if (push) begin
      fifo_addr_d[wr_ptr_q] = p2_addr_q;
      fifo_data_d[wr_ptr_q] = p2_cidx_q;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    // Remember the popped head so the port holds steady once the FIFO drains
    if (pop) begin
      last_addr_d = fifo_addr_q[rd_ptr_q];
      last_data_d = fifo_data_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    cnt_d = cnt_q;
    if (push && !pop)
      cnt_d = cnt_q + (PW+1)'(1);
    else if (pop && !push)
      cnt_d = cnt_q - (PW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid_q  <= 1'b0;
      p1_x_q      <= '0;
      p1_y_q      <= '0;
      p1_cidx_q   <= '0;
      p2_valid_q  <= 1'b0;
      p2_addr_q   <= '0;
      p2_cidx_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      clip_cnt_q  <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      p1_valid_q  <= p1_valid_d;
      p1_x_q      <= p1_x_d;
      p1_y_q      <= p1_y_d;
      p1_cidx_q   <= p1_cidx_d;
      p2_valid_q  <= p2_valid_d;
      p2_addr_q   <= p2_addr_d;
      p2_cidx_q   <= p2_cidx_d;
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      clip_cnt_q  <= clip_cnt_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
    end
  end

  assign bus.oe       = oe_w;
  assign bus.mem_we   = fifo_nempty;
  assign bus.mem_addr = fifo_nempty ? fifo_addr_q[rd_ptr_q] : last_addr_q;
  assign bus.mem_data = fifo_nempty ? fifo_data_q[rd_ptr_q] : last_data_q;
  assign clip_cnt     = clip_cnt_q;
  assign idle         = !p1_valid_q && !p2_valid_q && !fifo_nempty;
endmodule

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
Downstream stage of the shape renderers (circles, rectangles, lines). It consumes the renderer's pixel stream (x, y, cidx, drawing) and throttles the renderer through its oe output. Each pixel is clipped to the framebuffer bounds, converted to a linear address, buffered in a small FIFO, and written to the framebuffer memory through a valid/ready write port.

Parameters:
CORDW, 16, signed coordinate width (bits)
CIDXW, 4, colour index width (bits)
FB_WIDTH, 320, framebuffer width (pixels)
FB_HEIGHT, 180, framebuffer height (pixels)
FIFO_DEPTH, 4, write buffer entries; power of two, >=2
ADDRW, 16, framebuffer address width; must hold FB_WIDTH*FB_HEIGHT-1

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
x  in  CORDW  signed horizontal pixel position from renderer
y  in  CORDW  signed vertical pixel position from renderer
cidx  in  CIDXW  pixel colour index from renderer
drawing  in  1  renderer pixel valid
oe  out  1  output enable to renderer; pixel accepted when drawing && oe
mem_we  out  1  framebuffer write request (valid)
mem_ready  in  1  framebuffer accepts write this cycle
mem_addr  out  ADDRW  framebuffer write address
mem_data  out  CIDXW  framebuffer write colour
clip_cnt  out  16  count of clipped pixels; saturates at 16'hFFFF
idle  out  1  high when pipeline and FIFO are empty

Behaviour:
- Reset (async, rst_n low): clear p1_valid, p2_valid, FIFO pointers/count and clip_cnt. Outputs: mem_we=0, mem_addr=0, mem_data=0, clip_cnt=0, idle=1, oe=1 (FIFO_DEPTH>=2).
- Reset mid-operation: all in-flight and buffered pixels are discarded. mem_we drops immediately (asynchronously).
- Accept: in cycle N, drawing && oe captures {x, y, cidx} into stage P1 (p1_valid=1 at N+1). drawing && !oe: nothing is captured; the renderer holds.
- Stage P1 (clip):
  - Pixel is clipped if x<0, x>=FB_WIDTH, y<0 or y>=FB_HEIGHT (signed compares).
  - Clipped pixel: dropped and clip_cnt increments (saturating).
  - Otherwise: passes to P2 as p2_valid=1 at N+2.
- Stage P2 (address): addr = y*FB_WIDTH + x, registered, truncated to ADDRW. The entry is pushed into the FIFO at the end of that cycle.
- FIFO: first-word-fall-through.
  - mem_we = !empty; mem_addr/mem_data = head entry.
  - Pop when mem_we && mem_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - Empty FIFO: mem_we=0, addr/data hold their last values.
- Latency: a pixel accepted at N into an empty FIFO sees mem_we=1 at N+3. With mem_ready held high, throughput is 1 pixel/cycle.
- Backpressure: oe = (fifo_cnt + p1_valid + p2_valid) < FIFO_DEPTH. oe is combinational from registers only (no path from drawing or mem_ready), so the FIFO can never overflow.
- idle = !p1_valid && !p2_valid && fifo empty. The controller waits for renderer done && idle before a buffer swap.
- Ordering: framebuffer writes preserve pixel acceptance order; no writes are merged.

Optional Feature:
Macro FB_TRANSPARENT_EN.
- Defined: a P1 pixel with cidx==0 is dropped like a clipped pixel but does NOT increment clip_cnt. Clip check takes priority: an out-of-bounds cidx==0 pixel counts as clipped.
- Undefined: cidx 0 is written like any other colour.

Test Plan:
- Single pixel x=10, y=2, cidx=A, mem_ready=1 -> mem_we high exactly 3 cycles after acceptance, mem_addr=650, mem_data=A, then idle=1.
- Pixels x=-1, x=320, y=180, y=-5 (all cidx=3) -> no mem_we, clip_cnt=4, oe stays 1, idle=1.
- mem_ready=0, drawing held high -> exactly 4 pixels accepted (oe falls after 4th), FIFO full. Raise mem_ready -> writes drain in acceptance order, oe reasserts after the first pop.
- Stream 100 in-bounds pixels with mem_ready=1 -> 100 writes, no gaps after initial latency, addresses correct, clip_cnt=0.
- rst_n low for 1 cycle with 3 pixels buffered, mem_ready=0 -> mem_we=0 immediately, clip_cnt=0, idle=1; no stale write after release.
- FB_TRANSPARENT_EN defined: pixels (5,5,0), (5,6,7), (-1,0,0) -> one write addr=1925 data=7, clip_cnt=1.
